// File: rtl/pwm_burst_scheduler_if.sv
// Request, grant and PWM-generator signal bundle for pwm_burst_scheduler.
interface pwm_burst_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 6,
  parameter int BURST_W = 8
);
  logic                         enable;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*(CNT_W+1)-1:0] req_duty;
  logic [NUM_REQ*3-1:0]         req_clip;
  logic [NUM_REQ*BURST_W-1:0]   req_len;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic [CNT_W:0]               pwm_duty;
  logic                         pwm_en;
  logic                         pwm_sync;
  logic                         busy;

  modport master (
    output enable, req, req_duty, req_clip, req_len,
    input  grant, done, pwm_duty, pwm_en, pwm_sync, busy
  );

  modport slave (
    input  enable, req, req_duty, req_clip, req_len,
    output grant, done, pwm_duty, pwm_en, pwm_sync, busy
  );
endinterface

// File: rtl/pwm_burst_scheduler.sv
// Round-robin burst scheduler sharing one PWM generator among NUM_REQ requesters.
// All decisions are taken on the last cycle of a PWM period and take effect at count==0.
module pwm_burst_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int CNT_W       = 6,
  parameter int BURST_W     = 8,
  parameter int GAP_PERIODS = 1
) (
  input  logic                 sysclk,
  input  logic                 sys_rst_n,
  pwm_burst_scheduler_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = $clog2(GAP_PERIODS + 1);
  localparam logic [CNT_W:0] FULL = {1'b1, {CNT_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [BURST_W-1:0] r_remaining;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic [CNT_W:0]     r_duty;
  logic               r_en;
  logic               r_sync;

  logic               w_boundary;
  logic               w_win_valid;
  logic [IDX_W-1:0]   w_win_idx;
  int                 w_best;
  int                 w_dist;
  logic [CNT_W:0]     w_eff [NUM_REQ];
  logic [BURST_W-1:0] w_len [NUM_REQ];

  assign w_boundary = &r_count;

  // Per-requester effective duty: saturate to 100%, then cap at FULL >> clip.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [CNT_W:0]     w_duty;
    logic [CNT_W:0]     w_sat;
    logic [CNT_W:0]     w_lim;
    logic [BURST_W-1:0] w_len_raw;

    assign w_duty    = bus.req_duty[gi*(CNT_W+1) +: (CNT_W+1)];
    assign w_sat     = (w_duty > FULL) ? FULL : w_duty;
    assign w_lim     = FULL >> bus.req_clip[gi*3 +: 3];
    assign w_eff[gi] = (w_sat < w_lim) ? w_sat : w_lim;
    assign w_len_raw = bus.req_len[gi*BURST_W +: BURST_W];
    assign w_len[gi] = (w_len_raw == '0) ? BURST_W'(1) : w_len_raw;
  end

  // Winner is the requester at the smallest distance past rr_ptr.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_best      = NUM_REQ;
    w_dist      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 1 - int'(r_rr_ptr)) % NUM_REQ;
      if (bus.req[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_win_valid = 1'b1;
        w_win_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
      r_owner     <= '0;
      r_remaining <= '0;
      r_gap_cnt   <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_duty      <= '0;
      r_en        <= 1'b0;
      r_sync      <= 1'b0;
    end else begin
      r_count <= r_count + 1'b1;
      r_sync  <= w_boundary;
      r_done  <= '0;
      if (!bus.enable) begin
        r_state <= S_IDLE;
        r_grant <= '0;
        r_en    <= 1'b0;
        r_duty  <= '0;
      end else if (w_boundary) begin
        case (r_state)
          S_IDLE, S_GAP: begin
            if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
              r_gap_cnt <= r_gap_cnt - 1'b1;
            end else if (w_win_valid) begin
              r_state     <= S_RUN;
              r_rr_ptr    <= w_win_idx;
              r_owner     <= w_win_idx;
              r_remaining <= w_len[w_win_idx];
              r_grant     <= NUM_REQ'(1) << w_win_idx;
              r_en        <= 1'b1;
              r_duty      <= w_eff[w_win_idx];
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_RUN: begin
            // Final period wins over a simultaneous request drop.
            if ((r_remaining == BURST_W'(1)) || !bus.req[r_owner]) begin
              r_state   <= S_GAP;
              r_gap_cnt <= GAP_W'(GAP_PERIODS - 1);
              r_grant   <= '0;
              r_en      <= 1'b0;
              r_duty    <= '0;
              if (r_remaining == BURST_W'(1)) r_done <= r_grant;
            end else begin
              r_remaining <= r_remaining - 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.grant    = r_grant;
  assign bus.done     = r_done;
  assign bus.pwm_duty = r_duty;
  assign bus.pwm_en   = r_en;
  assign bus.pwm_sync = r_sync;
  assign bus.busy     = (r_state != S_IDLE);
endmodule
